tilelink_d_arbiter: RTL and testbench

//  Non-blocking N:1 TileLink-UL D-channel response arbiter: merges TLS slave D channels onto one master D channel.

---
 rtl/tl_pkg.sv | 22 ++
 rtl/tilelink_d_arbiter_if.sv | 48 ++++
 rtl/tl_rr_pick.sv | 28 ++
 rtl/tilelink_d_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_tilelink_d_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_pkg.sv
// Shared TileLink-UL D-channel definitions: opcodes, arbiter FSM states and
// the burst length helper used by the response arbiter.
package tl_pkg;

   localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
   localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;
   localparam logic [2:0] TL_HINT_ACK        = 3'd2;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } tl_arb_state_e;

   // Beats in a data-carrying message; anything that fits one beat is exactly 1.
   function automatic int unsigned tl_beats(input int unsigned size, input int unsigned dw_log2);
      if (size > dw_log2 - 3)
         return 32'd1 << (size - (dw_log2 - 3));
      else
         return 32'd1;
   endfunction

endpackage

// File: rtl/tilelink_d_arbiter_if.sv
// D-channel bundle between N slave response ports and the single master port.
// The slave modport is the arbiter's view; the master modport is the environment's.
interface tilelink_d_arbiter_if #(
   parameter int TLS   = 2,
   parameter int TL_RS = 2,
   parameter int TL_DW = 5,
   parameter int TL_SZ = 4
);

   logic [3*TLS-1:0]        slave_d_opcode;
   logic [2*TLS-1:0]        slave_d_param;
   logic [TL_SZ*TLS-1:0]    slave_d_size;
   logic [TL_RS*TLS-1:0]    slave_d_source;
   logic [TLS-1:0]          slave_d_denied;
   logic [TLS*2**TL_DW-1:0] slave_d_data;
   logic [TLS-1:0]          slave_d_corrupt;
   logic [TLS-1:0]          slave_d_valid;
   logic [TLS-1:0]          slave_d_ready;

   logic [2:0]              master_d_opcode;
   logic [1:0]              master_d_param;
   logic [TL_SZ-1:0]        master_d_size;
   logic [TL_RS-1:0]        master_d_source;
   logic                    master_d_denied;
   logic [2**TL_DW-1:0]     master_d_data;
   logic                    master_d_corrupt;
   logic                    master_d_valid;
   logic                    master_d_ready;

   modport slave (
      input  slave_d_opcode, slave_d_param, slave_d_size, slave_d_source,
             slave_d_denied, slave_d_data, slave_d_corrupt, slave_d_valid,
             master_d_ready,
      output slave_d_ready,
             master_d_opcode, master_d_param, master_d_size, master_d_source,
             master_d_denied, master_d_data, master_d_corrupt, master_d_valid
   );

   modport master (
      output slave_d_opcode, slave_d_param, slave_d_size, slave_d_source,
             slave_d_denied, slave_d_data, slave_d_corrupt, slave_d_valid,
             master_d_ready,
      input  slave_d_ready,
             master_d_opcode, master_d_param, master_d_size, master_d_source,
             master_d_denied, master_d_data, master_d_corrupt, master_d_valid
   );

endinterface

// File: rtl/tl_rr_pick.sv
// Combinational one-hot round-robin picker: the first requester at or after
// ptr (wrapping) is granted; no request gives an all-zero grant.
module tl_rr_pick #(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   logic found;
   int   idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tilelink_d_arbiter.sv
// N:1 TileLink-UL D-channel response arbiter with registered master output.
// Build option: define TL_DARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module tilelink_d_arbiter
   import tl_pkg::*;
#(
   parameter int TLS   = 2,
   parameter int TL_RS = 2,
   parameter int TL_DW = 5,
   parameter int TL_SZ = 4
) (
   input  logic tilelink_clock_i,
   input  logic tilelink_reset_i,
   tilelink_d_arbiter_if.slave d_bus
);

   localparam int IDX_W  = (TLS > 1) ? $clog2(TLS) : 1;
   localparam int CNT_W  = 2**TL_SZ - (TL_DW - 3);
   localparam int DATA_W = 2**TL_DW;
   localparam logic [TL_SZ-1:0] BEAT_SIZE = TL_SZ'(TL_DW - 3);

   tl_arb_state_e      state_reg, state_next;
   logic [IDX_W-1:0]   lock_reg, lock_next;
   logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;

   logic [IDX_W-1:0]   pick_ptr;
   logic [TLS-1:0]     pick_grant;
   logic [TLS-1:0]     grant;
   logic [TLS-1:0]     ready;
   logic               load;
   logic               xfer;
   logic [IDX_W-1:0]   win_idx;

   logic [2:0]         sel_opcode;
   logic [1:0]         sel_param;
   logic [TL_SZ-1:0]   sel_size;
   logic [TL_RS-1:0]   sel_source;
   logic               sel_denied;
   logic [DATA_W-1:0]  sel_data;
   logic               sel_corrupt;
   logic               is_multi;
   logic [CNT_W-1:0]   beats_m1;

   logic               valid_reg;
   logic [2:0]         opcode_reg;
   logic [1:0]         param_reg;
   logic [TL_SZ-1:0]   size_reg;
   logic [TL_RS-1:0]   source_reg;
   logic               denied_reg;
   logic [DATA_W-1:0]  data_reg;
   logic               corrupt_reg;

`ifdef TL_DARB_FIXED_PRIO_EN
   assign pick_ptr = '0;
`else
   logic [IDX_W-1:0]   ptr_reg, ptr_next;
   assign pick_ptr = ptr_reg;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      return (int'(idx) == TLS - 1) ? '0 : idx + 1'b1;
   endfunction
`endif

   tl_rr_pick #(
      .N  (TLS),
      .PW (IDX_W)
   ) u_pick (
      .req   (d_bus.slave_d_valid),
      .ptr   (pick_ptr),
      .grant (pick_grant)
   );

   // A burst owns the channel even while its slave has no beat ready.
   always_comb begin
      grant = pick_grant;
      if (state_reg == ARB_BURST)
         grant = TLS'(1) << lock_reg;
   end

   assign load  = !valid_reg || d_bus.master_d_ready;
   assign ready = grant & {TLS{load & tilelink_reset_i}};
   assign xfer  = |(ready & d_bus.slave_d_valid);
   assign d_bus.slave_d_ready = ready;

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < TLS; i++)
         if (grant[i])
            win_idx = IDX_W'(i);
   end

   assign sel_opcode  = d_bus.slave_d_opcode[win_idx*3 +: 3];
   assign sel_param   = d_bus.slave_d_param[win_idx*2 +: 2];
   assign sel_size    = d_bus.slave_d_size[win_idx*TL_SZ +: TL_SZ];
   assign sel_source  = d_bus.slave_d_source[win_idx*TL_RS +: TL_RS];
   assign sel_denied  = d_bus.slave_d_denied[win_idx];
   assign sel_data    = d_bus.slave_d_data[win_idx*DATA_W +: DATA_W];
   assign sel_corrupt = d_bus.slave_d_corrupt[win_idx];

   assign is_multi = (sel_opcode == TL_ACCESS_ACK_DATA) && (sel_size > BEAT_SIZE);
   assign beats_m1 = CNT_W'(tl_beats(32'(sel_size), TL_DW) - 32'd1);

   always_comb begin
      state_next    = state_reg;
      lock_next     = lock_reg;
      beat_cnt_next = beat_cnt_reg;
`ifndef TL_DARB_FIXED_PRIO_EN
      ptr_next      = ptr_reg;
`endif
      case (state_reg)
         ARB_IDLE: begin
            if (xfer && is_multi) begin
               lock_next     = win_idx;
               beat_cnt_next = beats_m1;
               state_next    = ARB_BURST;
            end
`ifndef TL_DARB_FIXED_PRIO_EN
            if (xfer && !is_multi)
               ptr_next = next_idx(win_idx);
`endif
         end
         ARB_BURST: begin
            if (xfer) begin
               beat_cnt_next = beat_cnt_reg - 1'b1;
               if (beat_cnt_reg == CNT_W'(1)) begin
                  state_next = ARB_IDLE;
`ifndef TL_DARB_FIXED_PRIO_EN
                  ptr_next   = next_idx(lock_reg);
`endif
               end
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   always_ff @(posedge tilelink_clock_i) begin
      if (!tilelink_reset_i) begin
         state_reg    <= ARB_IDLE;
         lock_reg     <= '0;
         beat_cnt_reg <= '0;
`ifndef TL_DARB_FIXED_PRIO_EN
         ptr_reg      <= '0;
`endif
      end else begin
         state_reg    <= state_next;
         lock_reg     <= lock_next;
         beat_cnt_reg <= beat_cnt_next;
`ifndef TL_DARB_FIXED_PRIO_EN
         ptr_reg      <= ptr_next;
`endif
      end
   end

   // Payload only moves on a transfer; an empty load just retires the valid.
   always_ff @(posedge tilelink_clock_i) begin
      if (!tilelink_reset_i) begin
         valid_reg   <= 1'b0;
         opcode_reg  <= '0;
         param_reg   <= '0;
         size_reg    <= '0;
         source_reg  <= '0;
         denied_reg  <= 1'b0;
         data_reg    <= '0;
         corrupt_reg <= 1'b0;
      end else if (load) begin
         valid_reg <= xfer;
         if (xfer) begin
            opcode_reg  <= sel_opcode;
            param_reg   <= sel_param;
            size_reg    <= sel_size;
            source_reg  <= sel_source;
            denied_reg  <= sel_denied;
            data_reg    <= sel_data;
            corrupt_reg <= sel_corrupt;
         end
      end
   end

   assign d_bus.master_d_valid   = valid_reg;
   assign d_bus.master_d_opcode  = opcode_reg;
   assign d_bus.master_d_param   = param_reg;
   assign d_bus.master_d_size    = size_reg;
   assign d_bus.master_d_source  = source_reg;
   assign d_bus.master_d_denied  = denied_reg;
   assign d_bus.master_d_data    = data_reg;
   assign d_bus.master_d_corrupt = corrupt_reg;

endmodule

// File: tb/tb_tilelink_d_arbiter.sv
// Directed bench for tilelink_d_arbiter (TLS=2, TL_DW=5) with a queue-based
// reference model compared every cycle plus hand-computed beat orders.
module tb_tilelink_d_arbiter;

   localparam int TLS   = 2;
   localparam int TL_RS = 2;
   localparam int TL_DW = 5;
   localparam int TL_SZ = 4;
`ifdef TL_DARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   typedef struct packed {
      logic [2:0]  op;
      logic [1:0]  param;
      logic [3:0]  size;
      logic [1:0]  src;
      logic        den;
      logic [31:0] data;
      logic        corr;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tilelink_d_arbiter_if #(.TLS(TLS), .TL_RS(TL_RS), .TL_DW(TL_DW), .TL_SZ(TL_SZ)) bus ();

   tilelink_d_arbiter #(.TLS(TLS), .TL_RS(TL_RS), .TL_DW(TL_DW), .TL_SZ(TL_SZ)) dut (
      .tilelink_clock_i (clk),
      .tilelink_reset_i (rst_n),
      .d_bus            (bus)
   );

   int checks = 0;
   int errors = 0;

   beat_t q0[$];
   beat_t q1[$];
   logic [1:0] hold = 2'b00;
   logic mready = 1'b1;

   // reference model state
   logic  m_known = 1'b0;
   logic  m_valid = 1'b0;
   beat_t m_pay   = '0;
   int    m_ptr   = 0;
   int    m_lock  = -1;
   int    m_left  = 0;

   int          out_src[$];
   logic [31:0] out_data[$];

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic beat_t mk(int op, int size, int src, logic [31:0] data);
      beat_t b;
      b       = '0;
      b.op    = 3'(op);
      b.param = 2'(src ^ 1);
      b.size  = 4'(size);
      b.src   = 2'(src);
      b.den   = data[1];
      b.data  = data;
      b.corr  = data[0];
      return b;
   endfunction

   function automatic int nbeats(beat_t b);
      if (b.op == 3'd1 && b.size > 4'd2)
         return 1 << (int'(b.size) - 2);
      return 1;
   endfunction

   function automatic beat_t dut_pay();
      beat_t b;
      b.op    = bus.master_d_opcode;
      b.param = bus.master_d_param;
      b.size  = bus.master_d_size;
      b.src   = bus.master_d_source;
      b.den   = bus.master_d_denied;
      b.data  = bus.master_d_data;
      b.corr  = bus.master_d_corrupt;
      return b;
   endfunction

   task automatic drive();
      beat_t b0, b1;
      b0 = (q0.size() > 0) ? q0[0] : '0;
      b1 = (q1.size() > 0) ? q1[0] : '0;
      bus.slave_d_opcode  = {b1.op, b0.op};
      bus.slave_d_param   = {b1.param, b0.param};
      bus.slave_d_size    = {b1.size, b0.size};
      bus.slave_d_source  = {b1.src, b0.src};
      bus.slave_d_denied  = {b1.den, b0.den};
      bus.slave_d_data    = {b1.data, b0.data};
      bus.slave_d_corrupt = {b1.corr, b0.corr};
      bus.slave_d_valid   = {(q1.size() > 0) && !hold[1], (q0.size() > 0) && !hold[0]};
      bus.master_d_ready  = mready;
   endtask

   // One clock: drive, compare against the model, then advance the model.
   task automatic step();
      logic [1:0] vld, exp_rdy;
      logic       load;
      int         xs, s, start;
      beat_t      b;
      drive();
      #1;
      vld     = bus.slave_d_valid;
      load    = !m_valid || mready;
      exp_rdy = 2'b00;
      start   = FIXED ? 0 : m_ptr;
      if (rst_n && load) begin
         if (m_lock >= 0)
            exp_rdy[m_lock] = 1'b1;
         else
            for (int k = 0; k < 2; k++) begin
               s = (start + k) % 2;
               if (vld[s] && exp_rdy == 2'b00)
                  exp_rdy[s] = 1'b1;
            end
      end
      chk("slave_d_ready", 64'(bus.slave_d_ready), 64'(exp_rdy));
      if (m_known) begin
         chk("master_d_valid", 64'(bus.master_d_valid), 64'(m_valid));
         chk("master_d_payload", 64'(dut_pay()), 64'(m_pay));
      end
      if (bus.master_d_valid === 1'b1 && mready) begin
         out_src.push_back(int'(bus.master_d_source));
         out_data.push_back(bus.master_d_data);
      end
      xs = -1;
      b  = '0;
      for (int k = 0; k < 2; k++)
         if (exp_rdy[k] && vld[k])
            xs = k;
      if (xs == 0) b = q0[0];
      if (xs == 1) b = q1[0];
      @(posedge clk);
      if (!rst_n) begin
         m_known = 1'b1;
         m_valid = 1'b0;
         m_pay   = '0;
         m_ptr   = 0;
         m_lock  = -1;
         m_left  = 0;
      end else if (load) begin
         m_valid = (xs >= 0);
         if (xs >= 0) begin
            m_pay = b;
            if (xs == 0) void'(q0.pop_front());
            else         void'(q1.pop_front());
            if (m_lock >= 0) begin
               m_left--;
               if (m_left == 0) begin
                  m_ptr  = (m_lock + 1) % 2;
                  m_lock = -1;
               end
            end else if (nbeats(b) > 1) begin
               m_lock = xs;
               m_left = nbeats(b) - 1;
            end else begin
               m_ptr = (xs + 1) % 2;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic drain(string name, int budget);
      int n;
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || m_valid) && n < budget) begin
         step();
         n++;
      end
      chk(name, 64'(n < budget), 64'd1);
   endtask

   task automatic do_reset();
      q0.delete();
      q1.delete();
      hold   = 2'b00;
      mready = 1'b1;
      rst_n  = 1'b0;
      step();
      rst_n  = 1'b1;
      out_src.delete();
      out_data.delete();
   endtask

   task automatic chk_data(string name, logic [31:0] exp[$]);
      chk({name, "_count"}, 64'(out_data.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < out_data.size(); i++)
         chk(name, 64'(out_data[i]), 64'(exp[i]));
      $display("%s: %0d beats observed on master", name, out_data.size());
   endtask

   initial begin
      logic [31:0] exp_d[$];
      int          exp_s[$];
      beat_t       snap;
      int          n;
      bit          held;

      @(negedge clk);

      // 1: reset with slave0 valid, then first beat one cycle after handshake
      q0.push_back(mk(0, 2, 0, 32'h11));
      repeat (2) begin
         step();
         chk("t1_reset_ready", 64'(bus.slave_d_ready), 64'd0);
         chk("t1_reset_valid", 64'(bus.master_d_valid), 64'd0);
      end
      rst_n = 1'b1;
      #1;
      chk("t1_ready_after_release", 64'(bus.slave_d_ready), 64'd1);
      step();
      chk("t1_first_valid", 64'(bus.master_d_valid), 64'd1);
      chk("t1_first_source", 64'(bus.master_d_source), 64'd0);
      chk("t1_first_data", 64'(bus.master_d_data), 64'h11);
      drain("t1_drain", 20);
      $display("t1 reset/first beat done");

      // 2: both slaves single-beat, full throughput, alternating sources
      do_reset();
      for (int j = 0; j < 4; j++) begin
         q0.push_back(mk(0, 2, 0, 32'h200 + j));
         q1.push_back(mk(0, 2, 1, 32'h210 + j));
      end
      repeat (9) step();
      chk("t2_beats_in_9_cycles", 64'(out_src.size()), 64'd8);
      for (int i = 0; i < out_src.size(); i++)
         chk("t2_source_order", 64'(out_src[i]), 64'(i % 2));
      drain("t2_drain", 20);
      $display("t2 alternation: %0d beats", out_src.size());

      // 3: 4-beat AccessAckData burst from slave0 holds off slave1
      do_reset();
      for (int j = 0; j < 4; j++) q0.push_back(mk(1, 4, 0, 32'hA0 + j));
      q1.push_back(mk(0, 2, 1, 32'hB0));
      q1.push_back(mk(0, 2, 1, 32'hB1));
      drain("t3_drain", 40);
      exp_d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB0, 32'hB1};
      chk_data("t3_order", exp_d);

      // 4: same, slave0 drops valid for 3 cycles mid-burst
      do_reset();
      for (int j = 0; j < 4; j++) q0.push_back(mk(1, 4, 0, 32'hA0 + j));
      q1.push_back(mk(0, 2, 1, 32'hB0));
      q1.push_back(mk(0, 2, 1, 32'hB1));
      n    = 0;
      held = 1'b0;
      while ((q0.size() > 0 || q1.size() > 0 || m_valid) && n < 60) begin
         if (!held && q0.size() == 2) begin
            hold[0] = 1'b1;
            held    = 1'b1;
            repeat (3) begin
               step();
               n++;
               chk("t4_slave1_stalled", 64'(bus.slave_d_ready[1]), 64'd0);
            end
            hold[0] = 1'b0;
         end else begin
            step();
            n++;
         end
      end
      chk("t4_drain", 64'(n < 60), 64'd1);
      chk_data("t4_order", exp_d);

      // 5: master stall for 5 cycles
      do_reset();
      for (int j = 0; j < 3; j++) begin
         q0.push_back(mk(0, 2, 0, 32'h500 + j));
         q1.push_back(mk(0, 2, 1, 32'h510 + j));
      end
      repeat (2) step();
      mready = 1'b0;
      snap   = dut_pay();
      chk("t5_stall_valid", 64'(bus.master_d_valid), 64'd1);
      repeat (5) begin
         step();
         chk("t5_payload_stable", 64'(dut_pay()), 64'(snap));
         chk("t5_ready_zero", 64'(bus.slave_d_ready), 64'd0);
      end
      mready = 1'b1;
      drain("t5_drain", 30);
      exp_d = '{32'h500, 32'h510, 32'h501, 32'h511, 32'h502, 32'h512};
      chk_data("t5_order", exp_d);

      // 6: arbitration policy with both slaves contending
      do_reset();
      for (int j = 0; j < 3; j++) q0.push_back(mk(0, 2, 0, 32'h600 + j));
      for (int j = 0; j < 2; j++) q1.push_back(mk(0, 2, 1, 32'h610 + j));
      drain("t6_drain", 30);
`ifdef TL_DARB_FIXED_PRIO_EN
      exp_s = '{0, 0, 0, 1, 1};
`else
      exp_s = '{0, 1, 0, 1, 0};
`endif
      chk("t6_count", 64'(out_src.size()), 64'(exp_s.size()));
      for (int i = 0; i < exp_s.size() && i < out_src.size(); i++)
         chk("t6_source_order", 64'(out_src[i]), 64'(exp_s[i]));
      $display("t6 policy: %0d beats", out_src.size());

      // 7: reset in the middle of a burst releases the lock
      do_reset();
      for (int j = 0; j < 4; j++) q0.push_back(mk(1, 4, 0, 32'h700 + j));
      q1.push_back(mk(0, 2, 1, 32'h710));
      repeat (2) step();
      rst_n = 1'b0;
      step();
      chk("t7_reset_valid", 64'(bus.master_d_valid), 64'd0);
      chk("t7_reset_payload", 64'(dut_pay()), 64'd0);
      chk("t7_reset_ready", 64'(bus.slave_d_ready), 64'd0);
      q0.delete();
      rst_n = 1'b1;
      out_src.delete();
      out_data.delete();
      drain("t7_drain", 20);
      exp_d = '{32'h710};
      chk_data("t7_after_reset", exp_d);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
